// File: rtl/dm_mmio_pkg.sv
// Shared address map and register bit positions
// for the data-side memory subsystem.
package dm_mmio_pkg;

  localparam logic [31:0] ADDR_LED  = 32'h0000_7F00;
  localparam logic [31:0] ADDR_SW   = 32'h0000_7F04;
  localparam logic [31:0] ADDR_TCNT = 32'h0000_7F10;
  localparam logic [31:0] ADDR_TCMP = 32'h0000_7F14;
  localparam logic [31:0] ADDR_TCTL = 32'h0000_7F18;
  localparam logic [31:0] RAM_LIMIT = 32'h0000_1000;

  localparam int TCTL_EN   = 0;
  localparam int TCTL_FLAG = 1;

  typedef enum logic [1:0] {
    TSEL_NONE,
    TSEL_TCMP,
    TSEL_TCTL
  } tsel_e;

  function automatic logic hit(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr[31:2] == base[31:2];
  endfunction

endpackage

// File: rtl/dm_timer.sv
// Compare-match timer: free count while enabled,
// wraps to 0 and sets a sticky flag on match.
module dm_timer
  import dm_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  tsel_e       sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tcnt_o,
  output logic [31:0] tcmp_o,
  output logic        en_o,
  output logic        flag_o
);

  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        en_q, en_d;
  logic        flag_q, flag_d;
  logic        match;
  logic        wr_tcmp, wr_tctl;

  assign match   = en_q && (tcnt_q == tcmp_q);
  assign wr_tcmp = we_i && (sel_i == TSEL_TCMP);
  assign wr_tctl = we_i && (sel_i == TSEL_TCTL);

  always_comb begin
    tcnt_d = tcnt_q;
    tcmp_d = tcmp_q;
    en_d   = en_q;
    flag_d = flag_q;
    if (match)
      tcnt_d = '0;
    else if (en_q)
      tcnt_d = tcnt_q + 32'd1;
    if (wr_tcmp)
      tcmp_d = wdata_i;
    if (wr_tctl)
      en_d = wdata_i[TCTL_EN];
    // a match on the same edge beats a clear
    if (match)
      flag_d = 1'b1;
    else if (wr_tctl && wdata_i[TCTL_FLAG])
      flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tcmp_q <= '0;
      en_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      en_q   <= en_d;
      flag_q <= flag_d;
    end
  end

  assign tcnt_o = tcnt_q;
  assign tcmp_o = tcmp_q;
  assign en_o   = en_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/dm_mmio.sv
// Data RAM plus LED/switch/timer peripherals
// behind the single-cycle CPU data port.
module dm_mmio
  import dm_mmio_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int SW_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite,
  input  logic [31:0]     aluout,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] led_o,
  output logic            irq
);

  localparam int AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  logic [31:0]     mem_q [DM_WORDS];
  logic [AW-1:0]   idx;
  logic [SW_W-1:0] led_q, led_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  logic sel_ram, sel_led, sel_sw;
  logic sel_tcnt, sel_tcmp, sel_tctl;
  logic pwe;

  tsel_e       tsel;
  logic [31:0] tcnt, tcmp;
  logic        t_en, t_flag;

  assign idx      = aluout[AW+1:2];
  assign sel_ram  = aluout < RAM_LIMIT;
  assign sel_led  = hit(aluout, ADDR_LED);
  assign sel_sw   = hit(aluout, ADDR_SW);
  assign sel_tcnt = hit(aluout, ADDR_TCNT);
  assign sel_tcmp = hit(aluout, ADDR_TCMP);
  assign sel_tctl = hit(aluout, ADDR_TCTL);
  assign pwe      = MemWrite && !rst;

  always_comb begin
    tsel = TSEL_NONE;
    if (sel_tcmp)
      tsel = TSEL_TCMP;
    else if (sel_tctl)
      tsel = TSEL_TCTL;
  end

  // RAM is deliberately outside reset and still
  // accepts a store issued in a reset cycle
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram)
      mem_q[idx] <= writedata;
  end

  always_comb begin
    led_d = led_q;
    if (pwe && sel_led)
      led_d = writedata[SW_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  dm_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (pwe),
    .sel_i   (tsel),
    .wdata_i (writedata),
    .tcnt_o  (tcnt),
    .tcmp_o  (tcmp),
    .en_o    (t_en),
    .flag_o  (t_flag)
  );

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      sel_ram:  readdata = mem_q[idx];
      sel_led:  readdata = 32'(led_q);
      sel_sw:   readdata = 32'(sw_sync_q);
      sel_tcnt: readdata = tcnt;
      sel_tcmp: readdata = tcmp;
      sel_tctl: readdata = {30'd0, t_flag, t_en};
      default:  readdata = '0;
    endcase
  end

  assign led_o = led_q;
  assign irq   = t_flag;

endmodule

// File: tb/tb_dm_mmio.sv
// Directed bench for dm_mmio: RAM, LED, switches,
// timer match/flag behaviour and reset.
module tb_dm_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw_i;
  logic [15:0] led_o;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  dm_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .sw_i      (sw_i),
    .led_o     (led_o),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    MemWrite = 1'b0;
    aluout   = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic st(
    input logic [31:0] a,
    input logic [31:0] d
  );
    MemWrite  = 1'b1;
    aluout    = a;
    writedata = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    MemWrite  = 1'b0;
    aluout    = '0;
    writedata = '0;
    sw_i      = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_led", {16'd0, led_o}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd("rst_tcnt", 32'h7F10, 32'd0);
    rd("rst_tctl", 32'h7F18, 32'd0);

    // RAM
    st(32'h14, 32'h1234_5678);
    st(32'h10, 32'h1111_1111);
    MemWrite  = 1'b1;
    aluout    = 32'h10;
    writedata = 32'hDEAD_BEEF;
    #1;
    chk("ram_no_wthru", readdata, 32'h1111_1111);
    tick();
    MemWrite = 1'b0;
    rd("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd("ram_14", 32'h14, 32'h1234_5678);
    st(32'hFFC, 32'h0BAD_CAFE);
    rd("ram_top", 32'hFFF, 32'h0BAD_CAFE);
    st(32'h1010, 32'hCAFE_F00D);
    rd("ram_10_kept", 32'h10, 32'hDEAD_BEEF);
    rd("unmap_1010", 32'h1010, 32'd0);
    rd("unmap_1234", 32'h1234, 32'd0);

    // LED
    st(32'h7F00, 32'h0001_FFFF);
    chk("led_o", {16'd0, led_o}, 32'h0000_FFFF);
    rd("led_rd", 32'h7F00, 32'h0000_FFFF);

    // reset mid-run: RAM store lands, LED store does not
    rst       = 1'b1;
    MemWrite  = 1'b1;
    aluout    = 32'h18;
    writedata = 32'hA5A5_A5A5;
    tick();
    aluout    = 32'h7F00;
    writedata = 32'h0000_00FF;
    tick();
    rst      = 1'b0;
    MemWrite = 1'b0;
    chk("rst_led_clr", {16'd0, led_o}, 32'd0);
    rd("rst_ram_keep", 32'h10, 32'hDEAD_BEEF);
    rd("rst_ram_st", 32'h18, 32'hA5A5_A5A5);

    // switch synchroniser
    sw_i = 16'h00A5;
    rd("sw_c0", 32'h7F04, 32'd0);
    tick();
    rd("sw_c1", 32'h7F04, 32'd0);
    tick();
    rd("sw_c2", 32'h7F04, 32'h0000_00A5);
    st(32'h7F04, 32'h0000_1234);
    rd("sw_ro", 32'h7F04, 32'h0000_00A5);

    // timer: TCMP=3, enable; match 4 edges later
    st(32'h7F14, 32'd3);
    rd("tcmp_rd", 32'h7F14, 32'd3);
    st(32'h7F18, 32'd1);
    rd("t_cnt0", 32'h7F10, 32'd0);
    tick();
    rd("t_cnt1", 32'h7F10, 32'd1);
    tick();
    tick();
    rd("t_cnt3", 32'h7F10, 32'd3);
    chk("t_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    chk("t_irq_set", {31'd0, irq}, 32'd1);
    rd("t_cnt_wrap", 32'h7F10, 32'd0);
    rd("t_tctl_3", 32'h7F18, 32'd3);

    // clear in a non-match cycle
    st(32'h7F18, 32'd3);
    chk("t_clr_irq", {31'd0, irq}, 32'd0);
    rd("t_clr_tctl", 32'h7F18, 32'd1);
    rd("t_clr_cnt", 32'h7F10, 32'd1);
    tick();
    tick();
    rd("t_cnt3b", 32'h7F10, 32'd3);

    // clear in the match cycle: set wins
    st(32'h7F18, 32'd3);
    chk("t_setwins", {31'd0, irq}, 32'd1);
    rd("t_setwins_cnt", 32'h7F10, 32'd0);

    // periodic re-set after clearing
    st(32'h7F18, 32'd3);
    chk("t_clr2", {31'd0, irq}, 32'd0);
    tick();
    tick();
    chk("t_pre2", {31'd0, irq}, 32'd0);
    tick();
    chk("t_period", {31'd0, irq}, 32'd1);

    // disable: last enabled edge counts, then hold
    st(32'h7F18, 32'd0);
    rd("t_dis_cnt", 32'h7F10, 32'd1);
    chk("t_dis_irq", {31'd0, irq}, 32'd1);
    tick();
    tick();
    rd("t_hold", 32'h7F10, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    rd("rst2_tcnt", 32'h7F10, 32'd0);
    rd("rst2_tcmp", 32'h7F14, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_mmio.md
# dm_mmio

Data-side memory subsystem for the single-cycle CPU, sitting directly downstream of the CPU's data port.
- Consumes the ALU result as address, the rt register value as store data, and the memory-write strobe.
- Returns load data combinationally within the same cycle.
- Decodes the address into a word-addressed data RAM and a small memory-mapped peripheral block: LED register, synchronised switch input, and a compare-match timer with interrupt flag.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high. All state changes on the rising edge of `clk`.

Parameters:
- `DM_WORDS`, default 1024: data RAM depth in 32-bit words; power of two, at most 1024.
- `SW_W`, default 16: width of switch input and LED register.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `MemWrite`  in  1  store strobe for the current instruction
- `aluout`  in  32  byte address
- `writedata`  in  32  store data
- `readdata`  out  32  load data, combinational from `aluout`
- `sw_i`  in  SW_W  asynchronous board switches
- `led_o`  out  SW_W  LED register contents
- `irq`  out  1  timer flag, level

## Operation
Address map. Byte address `aluout`; `aluout[1:0]` is ignored (word accesses only).
- RAM: `0x0000_0000`–`0x0000_0FFF`, indexed by `aluout[11:2]` modulo `DM_WORDS`; accesses wrap past depth.
- LED: `0x0000_7F00`, read/write. Bits above `SW_W` read 0, writes to them ignored.
- SW: `0x0000_7F04`, read-only. Two-flop synchronised `sw_i`, zero-extended.
- TCNT: `0x0000_7F10`, read-only. Timer count.
- TCMP: `0x0000_7F14`, read/write. Compare value.
- TCTL: `0x0000_7F18`.
  - bit0 EN, read/write.
  - bit1 FLAG, read; write 1 clears, write 0 has no effect.
  - Other bits read 0.
- Unmapped addresses read 0; writes to them and to read-only registers are ignored.

Timer:
- When EN=1, TCNT increments each cycle.
- When TCNT==TCMP, FLAG is set and TCNT loads 0 on that edge instead of incrementing.
- When EN=0, TCNT holds its value.
- Match is evaluated on pre-edge values. A TCMP write in the match cycle does not affect that cycle's compare.
- Simultaneous FLAG set and write-1-clear: set wins.
- `irq` = FLAG.

Reset values:
- LED, TCMP, TCNT, EN, FLAG, and both switch sync stages = 0.
- `led_o` = 0, `irq` = 0.
- RAM contents are not reset; they persist across `rst`.

## Timing
- Read: purely combinational, `aluout` → `readdata`, zero latency. Required by the single-cycle datapath.
- Write: takes effect at the rising edge where `MemWrite`=1. A read of the same address in the next cycle returns the new value. A same-cycle read returns the old value (no write-through).
- Switches: a `sw_i` change is visible on SW reads 2 cycles later.
- Timer period with EN=1 and TCMP=N: FLAG sets N+1 cycles after counting starts from 0, then every N+1 cycles.
- Reset asserted mid-operation: all registers return to reset values on that edge. A store in the reset cycle still writes RAM but not peripheral registers.

## Structure
- Package `dm_mmio_pkg` holds:
  - address constants: `ADDR_LED`, `ADDR_SW`, `ADDR_TCNT`, `ADDR_TCMP`, `ADDR_TCTL`, `RAM_LIMIT`;
  - TCTL bit indices `TCTL_EN` and `TCTL_FLAG`.
- Sub-module `dm_timer` contains:
  - TCNT/TCMP/EN/FLAG registers and the match logic;
  - a write interface (`we`, register select, data) and read outputs.
- Top level contains address decode, RAM array, LED register, switch synchroniser and read mux.

## Test plan
- Store `0xDEADBEEF` to `0x0000_0010`, load `0x0000_0010` next cycle → `readdata`=`0xDEADBEEF`. Load `0x0000_0014` → its own prior contents, unaffected.
- Store to `0x0000_1010` with `DM_WORDS`=1024 → ignored (unmapped). Load `0x0000_1234` → 0.
- Store `0x0001_FFFF` to LED → `led_o`=`0xFFFF` next cycle; LED read = `0x0000_FFFF`. Assert `rst` one cycle → `led_o`=0, RAM word at `0x10` unchanged.
- Set `sw_i`=`0x00A5` → SW read returns 0 for 2 cycles, then `0x0000_00A5`. A store to SW leaves its value unchanged.
- TCMP=3, TCTL=1 → FLAG/`irq` set 4 cycles later, TCNT reads 0 after the match edge, FLAG re-sets every 4 cycles.
- TCTL write `0x3` in the exact cycle TCNT==TCMP → FLAG stays 1 (set wins). Write `0x3` in a non-match cycle → FLAG clears, EN stays 1.
